mmio_console_ctrl: RTL and testbench
====================================

Name: mmio_console_ctrl

Overview:
- Memory-mapped console/halt controller on the CPU data bus, in the 0x80–0x8F peripheral window.
- Buffers characters stored by software in a FIFO and drains them one per handshake to a console sink (simulation printer or UART TX).
- Sequences end-of-run: on a write to END it drains pending characters, then raises a sticky halt flag.

Parameters:
- FIFO_DEPTH, 16: character FIFO entries; must be a power of two, at least 2.
- ADDR_W, 8: width of the bus address compared against the register map.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset; 0 = in reset.
- bus_req_i  in  1  bus access request.
- bus_we_i  in  1  1 = write, 0 = read.
- bus_addr_i  in  ADDR_W  register byte address.
- bus_wdata_i  in  8  write data (character).
- bus_ready_o  out  1  access accepted this cycle.
- bus_rdata_o  out  32  read data, valid the cycle after an accepted read.
- tx_valid_o  out  1  character available to the sink.
- tx_data_o  out  8  character at the FIFO head.
- tx_ready_i  in  1  sink accepts the character.
- sim_end_o  out  1  sticky halt indication.

Behaviour:
- Register map (all other addresses: reads return 0, writes are ignored, bus_ready_o=1):
  - 0x80 END (write only).
  - 0x81 TXDATA alias.
  - 0x84 TXDATA.
  - 0x88 STATUS (read only): bit0 full, bit1 empty, bits[15:8] occupancy count, bit16 sim_end.
  - 0x8C CYCLE (see Optional Feature).
- Reset (reset=0 at a clk edge):
  - FIFO emptied; state RUN.
  - tx_valid_o=0, tx_data_o=0, bus_rdata_o=0, sim_end_o=0.
  - Reset asserted during DRAIN discards all queued characters.
- Push: bus_req_i & bus_we_i & addr∈{0x81,0x84} in RUN writes bus_wdata_i into the FIFO.
- Full FIFO:
  - bus_ready_o=0 (CPU stalls) until an entry frees.
  - If a pop occurs in the same cycle, the push is accepted and bus_ready_o=1.
- Pop: tx_valid_o & tx_ready_i removes the head entry.
  - tx_valid_o = !empty.
  - tx_data_o is the head entry; it is stable while tx_valid_o=1 and tx_ready_i=0.
- Latency:
  - A push into an empty FIFO at edge N gives tx_valid_o=1 after edge N.
  - Simultaneous push and pop on a non-empty FIFO leaves the count unchanged.
- Pointers are log2(FIFO_DEPTH)+1 bits; the extra MSB distinguishes full from empty on wrap-around.
- Read: bus_rdata_o is registered; an accepted read at edge N is valid after edge N. Reads are always ready.
- FSM:
  - RUN: an END write goes to DRAIN.
  - DRAIN: TXDATA writes are ignored with bus_ready_o=1. When the FIFO is empty, go to DONE.
  - DONE: sim_end_o=1, held until reset. All writes are ignored; reads still work.
  - An END write with an empty FIFO reaches DONE after one DRAIN cycle: sim_end_o rises 2 edges after the write.
  - An END write in DRAIN or DONE has no effect.

Optional Feature:
- Macro CONSOLE_CYCLE_CNT_EN.
- Defined: a 32-bit free-running cycle counter.
  - Cleared by reset, increments every clk, wraps at 2^32−1 → 0.
  - Readable at 0x8C.
  - Freezes when sim_end_o rises, giving the total run length.
- Undefined: no counter logic; 0x8C reads return 0.

Decomposition:
- Shared package (my_pkg):
  - Register address constants CONSOLE_END=8'h80, CONSOLE_TX_ALT=8'h81, CONSOLE_TX=8'h84, CONSOLE_STATUS=8'h88, CONSOLE_CYCLE=8'h8C.
  - The FSM enum console_state_t {RUN, DRAIN, DONE}.
- Sub-module: console_fifo, a synchronous FIFO with push/pop/full/empty/count, parameterised by DEPTH and data width. It is reusable for the future UART RX path.

Test Plan:
- Reset then write 'H','i' (0x48, 0x69) to 0x84 with tx_ready_i=1 → tx_data_o shows 0x48 then 0x69 on consecutive cycles, each one edge after its write; then empty (STATUS bit1=1).
- tx_ready_i=0, 17 writes to 0x84 (FIFO_DEPTH=16):
  - 16 accepted; STATUS reads full=1, count=16.
  - The 17th stalls with bus_ready_o=0.
  - Raising tx_ready_i for 1 cycle accepts the 17th in that same cycle; count stays 16.
- Queue 3 chars with tx_ready_i=0, write 0x80, then write 0x81 (ignored):
  - sim_end_o stays 0.
  - Release tx_ready_i → exactly 3 chars drain, then sim_end_o=1 and stays high.
- END write on an empty FIFO → sim_end_o=1 two edges later.
- Assert reset for 1 cycle during DRAIN with 5 chars queued → tx_valid_o=0, sim_end_o=0, STATUS=0x2; new writes work.
- CONSOLE_CYCLE_CNT_EN defined:
  - Read 0x8C twice, 10 cycles apart → difference 10.
  - After sim_end_o, two reads return equal values.
  - Undefined → reads return 0.

Source files
------------

// File: rtl/my_pkg.sv
// Shared definitions for the MMIO console controller.
//   - Register byte addresses of the console window.
//   - Sequencing states of the end-of-run controller.
package my_pkg;

  localparam logic [7:0] CONSOLE_END    = 8'h80;
  localparam logic [7:0] CONSOLE_TX_ALT = 8'h81;
  localparam logic [7:0] CONSOLE_TX     = 8'h84;
  localparam logic [7:0] CONSOLE_STATUS = 8'h88;
  localparam logic [7:0] CONSOLE_CYCLE  = 8'h8C;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } console_state_t;

endpackage

// File: rtl/console_fifo.sv
// Synchronous FIFO with push/pop, full/empty flags and an occupancy count.
// Ports:
//   clk, reset (sync, active-low)
//   push_i/wdata_i : write request and data
//   pop_i          : remove head entry (ignored when empty)
//   rdata_o        : head entry (undefined contents when empty)
//   full_o/empty_o : status flags
//   count_o        : number of stored entries (0..DEPTH)
// A push on a full FIFO is accepted only when a pop happens in the same cycle.
module console_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = DEPTH[AW:0];

  // Pointers carry one extra MSB so full and empty differ after wrap-around.
  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push, do_pop;

  assign count_o = wr_q - rd_q;
  assign full_o  = (count_o == DEPTH_CNT);
  assign empty_o = (wr_q == rd_q);
  assign rdata_o = mem_q[rd_q[AW-1:0]];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    mem_d = mem_q;
    if (do_push) begin
      mem_d[wr_q[AW-1:0]] = wdata_i;
      wr_d = wr_q + 1'b1;
    end
    if (do_pop) begin
      rd_d = rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage is not reset; the read side is gated by empty_o.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/mmio_console_ctrl.sv
// Memory-mapped console / halt controller (0x80-0x8F window).
// Buffers characters written by software and drains them to a console sink
// one per valid/ready handshake. A write to END drains the queue and then
// raises a sticky halt flag.
// Ports:
//   clk, reset (sync, active-low)
//   bus_req_i/bus_we_i/bus_addr_i/bus_wdata_i : CPU access
//   bus_ready_o : access accepted (0 only for a TXDATA write to a full FIFO)
//   bus_rdata_o : registered read data, valid the cycle after a read
//   tx_valid_o/tx_data_o/tx_ready_i : console sink handshake
//   sim_end_o   : sticky halt indication
// Build option: CONSOLE_CYCLE_CNT_EN adds a 32-bit run-length counter at 0x8C.
//
// State | meaning
// RUN   | normal operation, characters accepted
// DRAIN | END seen, TXDATA writes dropped, waiting for FIFO to empty
// DONE  | halt flag raised until reset
module mmio_console_ctrl #(
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bus_req_i,
  input  logic              bus_we_i,
  input  logic [ADDR_W-1:0] bus_addr_i,
  input  logic [7:0]        bus_wdata_i,
  output logic              bus_ready_o,
  output logic [31:0]       bus_rdata_o,
  output logic              tx_valid_o,
  output logic [7:0]        tx_data_o,
  input  logic              tx_ready_i,
  output logic              sim_end_o
);

  import my_pkg::*;

  localparam int AW = $clog2(FIFO_DEPTH);

  console_state_t state_q, state_d;
  logic [31:0]    rdata_q, rdata_d;
  logic           fifo_full, fifo_empty;
  logic [AW:0]    fifo_count;
  logic [7:0]     fifo_head, count8;
  logic           wr_acc, rd_acc, is_tx, is_end;
  logic           push_req, pop, stall, push;
  logic [31:0]    status_w, cyc_w;

  assign wr_acc = bus_req_i & bus_we_i;
  assign rd_acc = bus_req_i & ~bus_we_i;
  assign is_tx  = (bus_addr_i == ADDR_W'(CONSOLE_TX)) |
                  (bus_addr_i == ADDR_W'(CONSOLE_TX_ALT));
  assign is_end = (bus_addr_i == ADDR_W'(CONSOLE_END));

  assign push_req = wr_acc & is_tx & (state_q == RUN);
  assign pop      = ~fifo_empty & tx_ready_i;
  // A full FIFO still takes the push when the head leaves in the same cycle.
  assign stall    = push_req & fifo_full & ~pop;
  assign push     = push_req & ~stall;

  console_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .wdata_i (bus_wdata_i),
    .pop_i   (pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign count8   = 8'(fifo_count);
  assign status_w = {15'd0, sim_end_o, count8, 6'd0, fifo_empty, fifo_full};

`ifdef CONSOLE_CYCLE_CNT_EN
  logic [31:0] cyc_q, cyc_d;

  // Stops counting once halted so the value reports total run length.
  assign cyc_d = (state_q == DONE) ? cyc_q : cyc_q + 32'd1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cyc_q <= '0;
    end else begin
      cyc_q <= cyc_d;
    end
  end

  assign cyc_w = cyc_q;
`else
  assign cyc_w = '0;
`endif

  always_comb begin
    rdata_d = rdata_q;
    if (rd_acc) begin
      if (bus_addr_i == ADDR_W'(CONSOLE_STATUS)) begin
        rdata_d = status_w;
      end else if (bus_addr_i == ADDR_W'(CONSOLE_CYCLE)) begin
        rdata_d = cyc_w;
      end else begin
        rdata_d = '0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (wr_acc & is_end) state_d = DRAIN;
      DRAIN:   if (fifo_empty)      state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= RUN;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus_ready_o = ~stall;
  assign bus_rdata_o = rdata_q;
  assign tx_valid_o  = ~fifo_empty;
  assign tx_data_o   = fifo_empty ? 8'h00 : fifo_head;
  assign sim_end_o   = (state_q == DONE);

endmodule

// File: tb/tb_mmio_console_ctrl.sv
// Self-checking bench for mmio_console_ctrl: directed scenarios followed by
// random traffic, all checked against a queue-based reference model.
module tb_mmio_console_ctrl;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        bus_req_i, bus_we_i, tx_ready_i;
  logic [7:0]  bus_addr_i, bus_wdata_i, tx_data_o;
  logic        bus_ready_o, tx_valid_o, sim_end_o;
  logic [31:0] bus_rdata_o;

  mmio_console_ctrl #(.FIFO_DEPTH(DEPTH), .ADDR_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus_req_i   (bus_req_i),
    .bus_we_i    (bus_we_i),
    .bus_addr_i  (bus_addr_i),
    .bus_wdata_i (bus_wdata_i),
    .bus_ready_o (bus_ready_o),
    .bus_rdata_o (bus_rdata_o),
    .tx_valid_o  (tx_valid_o),
    .tx_data_o   (tx_data_o),
    .tx_ready_i  (tx_ready_i),
    .sim_end_o   (sim_end_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model
  logic [7:0]  mq[$];
  bit          m_draining, m_done;
  logic [31:0] m_rdata, m_cyc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] reg_value(input logic [7:0] addr);
    logic [31:0] v;
    v = 32'd0;
    if (addr == 8'h88) begin
      v = (32'(m_done) << 16) | (32'(mq.size()) << 8) |
          ((mq.size() == 0) ? 32'd2 : 32'd0) | ((mq.size() == DEPTH) ? 32'd1 : 32'd0);
    end else if (addr == 8'h8C) begin
`ifdef CONSOLE_CYCLE_CNT_EN
      v = m_cyc;
`else
      v = 32'd0;
`endif
    end
    return v;
  endfunction

  task automatic check_outs(input string where);
    chk({where, "_tx_valid"}, 32'(tx_valid_o), 32'(mq.size() > 0));
    chk({where, "_tx_data"},  32'(tx_data_o),  (mq.size() > 0) ? 32'(mq[0]) : 32'd0);
    chk({where, "_sim_end"},  32'(sim_end_o),  32'(m_done));
    chk({where, "_rdata"},    bus_rdata_o,     m_rdata);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; bus_req_i = 1'b0; bus_we_i = 1'b0;
    @(posedge clk);
    #1;
    mq.delete();
    m_draining = 1'b0; m_done = 1'b0; m_rdata = 32'd0; m_cyc = 32'd0;
    check_outs("reset");
  endtask

  task automatic step(input bit req, input bit we, input logic [7:0] addr,
                      input logic [7:0] wd, input bit rdy);
    bit is_tx, is_end, pop, want, rdy_exp, drain_n, done_n;
    @(negedge clk);
    reset = 1'b1; bus_req_i = req; bus_we_i = we;
    bus_addr_i = addr; bus_wdata_i = wd; tx_ready_i = rdy;
    is_tx   = req && we && (addr == 8'h81 || addr == 8'h84);
    is_end  = req && we && (addr == 8'h80);
    pop     = rdy && (mq.size() > 0);
    want    = is_tx && !m_draining && !m_done;
    rdy_exp = !(want && mq.size() == DEPTH && !pop);
    #1;
    chk("bus_ready", 32'(bus_ready_o), 32'(rdy_exp));
    if (req && !we) m_rdata = reg_value(addr);
    drain_n = m_draining; done_n = m_done;
    if (m_draining && mq.size() == 0) begin drain_n = 1'b0; done_n = 1'b1; end
    if (!m_draining && !m_done && is_end) drain_n = 1'b1;
    if (!m_done) m_cyc = m_cyc + 32'd1;
    m_draining = drain_n; m_done = done_n;
    if (pop) void'(mq.pop_front());
    if (want && rdy_exp) mq.push_back(wd);
    @(posedge clk);
    #1;
    check_outs("step");
  endtask

  initial begin : main
    logic [31:0] r1;
    logic [7:0]  a;
    reset = 1'b0; bus_req_i = 1'b0; bus_we_i = 1'b0; bus_addr_i = 8'h00;
    bus_wdata_i = 8'h00; tx_ready_i = 1'b0;
    mq.delete(); m_draining = 1'b0; m_done = 1'b0; m_rdata = 32'd0; m_cyc = 32'd0;

    // Reset and "Hi"
    do_reset();
    do_reset();
    step(1, 0, 8'h88, 8'h00, 1);
    chk("reset_status", bus_rdata_o, 32'h0000_0002);
    step(1, 1, 8'h84, 8'h48, 1);
    chk("hi_first", 32'(tx_data_o), 32'h48);
    step(1, 1, 8'h84, 8'h69, 1);
    chk("hi_second", 32'(tx_data_o), 32'h69);
    step(0, 0, 8'h00, 8'h00, 1);
    step(1, 0, 8'h88, 8'h00, 1);
    chk("hi_empty", 32'(bus_rdata_o[1]), 32'd1);

    // Fill to full, stall, then single-cycle release
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1, 1, 8'h84, 8'(8'h30 + i), 0);
    step(1, 0, 8'h88, 8'h00, 0);
    chk("full_status", bus_rdata_o, 32'h0000_1001);
    step(1, 1, 8'h84, 8'hAA, 0);
    chk("stall_ready", 32'(bus_ready_o), 32'd0);
    step(1, 1, 8'h84, 8'hAA, 0);
    step(1, 1, 8'h84, 8'hAA, 1);
    step(1, 0, 8'h88, 8'h00, 0);
    chk("full_after_swap", bus_rdata_o, 32'h0000_1001);

    // END with queued characters, ignored alias write during drain
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 1, 8'h84, 8'(8'h41 + i), 0);
    step(1, 1, 8'h80, 8'h00, 0);
    step(1, 1, 8'h81, 8'h5A, 0);
    step(0, 0, 8'h00, 8'h00, 0);
    chk("drain_hold", 32'(sim_end_o), 32'd0);
    for (int i = 0; i < 6; i++) step(0, 0, 8'h00, 8'h00, 1);
    chk("drain_done", 32'(sim_end_o), 32'd1);
    step(1, 1, 8'h84, 8'h77, 1);
    chk("done_ignores", 32'(tx_valid_o), 32'd0);

    // END on empty FIFO
    do_reset();
    step(1, 1, 8'h80, 8'h00, 1);
    chk("end_edge1", 32'(sim_end_o), 32'd0);
    step(0, 0, 8'h00, 8'h00, 1);
    chk("end_edge2", 32'(sim_end_o), 32'd1);

    // Reset during DRAIN
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 1, 8'h84, 8'(8'h61 + i), 0);
    step(1, 1, 8'h80, 8'h00, 0);
    step(0, 0, 8'h00, 8'h00, 0);
    do_reset();
    chk("rst_drain_valid", 32'(tx_valid_o), 32'd0);
    step(1, 0, 8'h88, 8'h00, 0);
    chk("rst_drain_status", bus_rdata_o, 32'h0000_0002);
    step(1, 1, 8'h84, 8'h55, 0);
    chk("rst_drain_write", 32'(tx_data_o), 32'h55);

    // Cycle counter
    do_reset();
    step(1, 0, 8'h8C, 8'h00, 1);
    r1 = bus_rdata_o;
    for (int i = 0; i < 9; i++) step(0, 0, 8'h00, 8'h00, 1);
    step(1, 0, 8'h8C, 8'h00, 1);
`ifdef CONSOLE_CYCLE_CNT_EN
    chk("cyc_diff", bus_rdata_o - r1, 32'd10);
`else
    chk("cyc_zero", bus_rdata_o | r1, 32'd0);
`endif
    step(1, 1, 8'h80, 8'h00, 1);
    step(0, 0, 8'h00, 8'h00, 1);
    step(1, 0, 8'h8C, 8'h00, 1);
    r1 = bus_rdata_o;
    step(0, 0, 8'h00, 8'h00, 1);
    step(1, 0, 8'h8C, 8'h00, 1);
    chk("cyc_frozen", bus_rdata_o, r1);

    // Random traffic
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 79) == 0) begin
        do_reset();
      end else begin
        case ($urandom_range(0, 5))
          0: a = 8'h80;
          1: a = 8'h81;
          2: a = 8'h84;
          3: a = 8'h88;
          4: a = 8'h8C;
          default: a = 8'($urandom);
        endcase
        if (a == 8'h80 && $urandom_range(0, 9) != 0) a = 8'h84;
        step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0), a,
             8'($urandom), 1'($urandom_range(0, 2) == 0));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
